// File: rtl/multdiv_iter.sv
// Iterative radix-2 multiplier/divider: shift-add multiply, restoring divide.
// Latency: exactly WIDTH cycles from accepted start to the one-cycle data_resultRDY pulse.
// Backpressure: none; starts are ignored while busy=1. Define MULTDIV_SIGNED_EN for two's-complement operation.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_mult;
  // Multiply: acc_hi = running upper half, acc_lo = multiplier shifting out.
  // Divide:   acc_hi = partial remainder, acc_lo = dividend shifting out / quotient shifting in.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd_m;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             start;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt, div_hi_nxt, div_lo_nxt;
  logic [2*WIDTH-1:0] prod;
  logic             div_zero;
  logic [WIDTH-1:0] fin_res;
  logic             fin_exc;

`ifdef MULTDIV_SIGNED_EN
  logic             neg;
  logic             neg_start;
  logic [2*WIDTH-1:0] sprod;
  logic [WIDTH-1:0] squot;
`endif

  assign start = ctrl_MULT | ctrl_DIV;

  // Operand magnitudes captured at acceptance (identity in the unsigned build)
  always_comb begin
`ifdef MULTDIV_SIGNED_EN
    mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    neg_start = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`else
    mag_a = data_operandA;
    mag_b = data_operandB;
`endif
  end

  // One radix-2 step for both operations; the shift value never exceeds 2*divisor, so the top bit only ever means "subtract"
  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_m} : '0);
    mul_hi_nxt = mul_sum[WIDTH:1];
    mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
    div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    div_diff   = div_shift - {1'b0, opnd_m};
    div_ok     = div_shift[WIDTH] | ~div_diff[WIDTH];
    div_hi_nxt = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_nxt = {acc_lo[WIDTH-2:0], div_ok};
  end

  // Final result and exception from the last step's outputs, with sign restored when enabled
  always_comb begin
    prod     = {mul_hi_nxt, mul_lo_nxt};
    div_zero = (opnd_m == '0);
    fin_res  = '0;
    fin_exc  = 1'b0;
`ifdef MULTDIV_SIGNED_EN
    sprod = neg ? -prod : prod;
    squot = neg ? -div_lo_nxt : div_lo_nxt;
    if (is_mult) begin
      fin_res = sprod[WIDTH-1:0];
      fin_exc = ~((&sprod[2*WIDTH-1:WIDTH-1]) | ~(|sprod[2*WIDTH-1:WIDTH-1]));
    end else if (div_zero) begin
      fin_exc = 1'b1;
    end else begin
      fin_res = squot;
      // Only -2^(WIDTH-1) / -1 yields a positive quotient magnitude of 2^(WIDTH-1)
      fin_exc = div_lo_nxt[WIDTH-1] & ~neg;
    end
`else
    if (is_mult) begin
      fin_res = prod[WIDTH-1:0];
      fin_exc = |prod[2*WIDTH-1:WIDTH];
    end else if (div_zero) begin
      fin_exc = 1'b1;
    end else begin
      fin_res = div_lo_nxt;
    end
`endif
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      is_mult        <= 1'b0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      opnd_m         <= '0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
      neg            <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Multiply wins when both starts are asserted
            is_mult <= ctrl_MULT;
            acc_hi  <= '0;
            acc_lo  <= ctrl_MULT ? mag_b : mag_a;
            opnd_m  <= ctrl_MULT ? mag_a : mag_b;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef MULTDIV_SIGNED_EN
            neg     <= neg_start;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= is_mult ? mul_hi_nxt : div_hi_nxt;
          acc_lo <= is_mult ? mul_lo_nxt : div_lo_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            cnt            <= '0;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= fin_res;
            data_exception <= fin_exc;
            state          <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
module tb_multdiv_iter;

`ifdef MULTDIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        mult8 = 1'b0, div8 = 1'b0;
  logic [7:0]  res8;
  logic        exc8, rdy8, busy8;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  exp_t q32[$];
  exp_t q8[$];

  multdiv_iter #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  multdiv_iter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset),
    .data_operandA(a8), .data_operandB(b8),
    .ctrl_MULT(mult8), .ctrl_DIV(div8),
    .data_result(res8), .data_exception(exc8),
    .data_resultRDY(rdy8), .busy(busy8)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: every RDY pulse must match the oldest pending expectation
  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (q32.size() == 0) begin
        chk("spurious_rdy32", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("result32", data_result, e.res);
        chk("exc32", data_exception, e.exc);
        chk("latency32", cyc, e.cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (rdy8) begin
      if (q8.size() == 0) begin
        chk("spurious_rdy8", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("result8", res8, e.res);
        chk("exc8", exc8, e.exc);
        chk("latency8", cyc, e.cyc);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  // Called at a negedge; returns at the negedge after acceptance with cyc == c0
  task automatic issue(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee, input bit push, output int c0);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = mul;
    ctrl_DIV = dv;
    c0 = cyc + 1;
    if (push) q32.push_back('{er, ee, c0 + 32});
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0BAD_F00D;
  endtask

  localparam int NV = 8;
  bit          v_mul [NV] = '{1, 0, 0, 1, 1, 1, 0, 1};
  bit          v_div [NV] = '{0, 1, 1, 0, 0, 0, 1, 1};
  logic [31:0] v_a   [NV] = '{32'd7, 32'hFFFF_FFF8, 32'd100, 32'h4000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd5};
  logic [31:0] v_b   [NV] = '{32'd6, 32'd3, 32'd0, 32'd4,
                              32'd1, 32'd5, 32'hFFFF_FFFF, 32'd3};
  logic [31:0] v_r   [NV] = '{32'd42, SGN ? 32'hFFFF_FFFE : 32'h5555_5552, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFF1, SGN ? 32'h8000_0000 : 32'd0, 32'd15};
  logic        v_e   [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, !SGN, SGN, 1'b0};

  initial begin
    int c0, c1, c8;
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rdy", data_resultRDY, 1'b0);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", data_exception, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // 8-bit instance: 15*17 = 255, overflows only as signed
    a8 = 8'd15; b8 = 8'd17; mult8 = 1'b1;
    c8 = cyc + 1;
    q8.push_back('{32'hFF, SGN, c8 + 8});
    @(negedge clock);
    mult8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;

    for (int i = 0; i < NV; i++) begin
      issue(v_mul[i], v_div[i], v_a[i], v_b[i], v_r[i], v_e[i], 1'b1, c0);
      chk("busy_after_start", busy, 1'b1);
      wait_cyc(c0 + 31);
      chk("busy_last_run", busy, 1'b1);
      wait_cyc(c0 + 32);
      chk("busy_at_done", busy, 1'b0);
      if (i % 2 == 1) repeat (3) @(negedge clock);
    end

    // Start ignored while busy, then a new start in the DONE cycle
    issue(1'b1, 1'b0, 32'd3, 32'd5, 32'd15, 1'b0, 1'b1, c0);
    wait_cyc(c0 + 4);
    data_operandA = 32'd9; data_operandB = 32'd3; ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_cyc(c0 + 32);
    chk("done_rdy", data_resultRDY, 1'b1);
    issue(1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1, c1);
    chk("done_restart_cycle", c1, c0 + 33);
    wait_cyc(c1 + 33);

    // Reset mid-operation aborts without a result
    issue(1'b1, 1'b0, 32'd11, 32'd13, 32'd0, 1'b0, 1'b0, c0);
    wait_cyc(c0 + 9);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", data_result, 32'd0);
    chk("abort_exc", data_exception, 1'b0);
    chk("abort_rdy", data_resultRDY, 1'b0);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    for (int k = 0; k < 200 && (q32.size() != 0 || q8.size() != 0); k++) @(negedge clock);
    chk("pending32", q32.size(), 0);
    chk("pending8", q8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multdiv_iter.md
MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 Port clock  input  1  single clock, all state updates on rising edge.
REQ-003 Port reset  input  1  reset is synchronous and active-high.
REQ-004 Port data_operandA  input  WIDTH  multiplicand / dividend.
REQ-005 Port data_operandB  input  WIDTH  multiplier / divisor.
REQ-006 Port ctrl_MULT  input  1  start multiply; sampled only when busy=0.
REQ-007 Port ctrl_DIV  input  1  start divide; sampled only when busy=0.
REQ-008 Port data_result  output  WIDTH  product low WIDTH bits or quotient.
REQ-009 Port data_exception  output  1  overflow or divide-by-zero flag for data_result.
REQ-010 Port data_resultRDY  output  1  one-cycle completion pulse.
REQ-011 Port busy  output  1  operation in flight; starts ignored while high.

Function
REQ-012 The block SHALL implement states IDLE, RUN, DONE; IDLE->RUN on accepted start, RUN->DONE after WIDTH iterations, DONE->IDLE next edge unless a new start is accepted (DONE->RUN).
REQ-013 A start SHALL be accepted at edge E0 when busy=0 and ctrl_MULT or ctrl_DIV is 1; operands and operation SHALL be latched at E0.
REQ-014 If ctrl_MULT and ctrl_DIV are both 1 at acceptance, multiply SHALL take priority.
REQ-015 Iteration SHALL be radix-2 (shift-add multiply, restoring divide), one step per edge E1..E_WIDTH, via a counter of ceil(log2(WIDTH+1)) bits.
REQ-016 At edge E_WIDTH data_result and data_exception SHALL be registered, data_resultRDY SHALL go 1 for exactly one cycle, busy SHALL go 0.
REQ-017 busy SHALL be 1 from E0 through the cycle before E_WIDTH; latency start-to-RDY is exactly WIDTH cycles.
REQ-018 data_result and data_exception SHALL hold their last completed values until the next completion.
REQ-019 Starts asserted while busy=1 SHALL be ignored with no side effects.
REQ-020 Multiply: data_exception=1 iff the full 2*WIDTH product is not representable in WIDTH bits (signedness per REQ-026/027); data_result = low WIDTH bits regardless.
REQ-021 Divide by zero: data_result=0, data_exception=1, same WIDTH-cycle latency.
REQ-022 Divide: quotient truncates toward zero; remainder is not output.
REQ-023 Operand changes after E0 SHALL NOT affect the in-flight result.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, counter 0, busy=0, data_resultRDY=0, data_result=0, data_exception=0, overriding any start in the same cycle.
REQ-025 Reset mid-operation SHALL abort without emitting data_resultRDY.

Configuration
REQ-026 With MULTDIV_SIGNED_EN defined: operands and results are two's complement; operands are converted to magnitude at E0, sign applied at E_WIDTH; divide of -2^(WIDTH-1) by -1 SHALL give data_result=-2^(WIDTH-1), data_exception=1.
REQ-027 Without MULTDIV_SIGNED_EN: operands and results are unsigned; no sign logic is synthesised; divide never overflows except by zero.

Verification (WIDTH=32 unless stated)
REQ-028 Signed: ctrl_MULT, A=7, B=6 at E0 -> RDY=1 at cycle E32 only, result=42, exception=0, busy 1 during E1..E31.
REQ-029 Signed: ctrl_DIV, A=-8, B=3 -> result=-2 (0xFFFFFFFE), exception=0; then A=100, B=0 -> result=0, exception=1 after 32 cycles.
REQ-030 Signed: ctrl_MULT, A=0x40000000, B=4 -> result=0x00000000, exception=1; unsigned build A=0xFFFFFFFF, B=1 -> result=0xFFFFFFFF, exception=0.
REQ-031 Start A=3,B=5 multiply, pulse ctrl_DIV A=9,B=3 at E5 -> ignored; single RDY at E32 with result=15; divide issued in DONE cycle accepted, RDY 32 cycles later with result=3.
REQ-032 Start multiply, assert reset at E10 -> busy=0, result=0 next cycle, no RDY for 40 cycles.
REQ-033 WIDTH=8 signed: A=15, B=17 -> result=0xFF, exception=1, RDY 8 cycles after start; unsigned build same -> exception=0.
